poly_square_osc: RTL and testbench

- Multi-channel square-wave tone generator for polyphonic note playback (chords).
- NUM_CH independent counter-based oscillators, each with its own half-period, enable, and per-channel toggle-edge strobe.
- A registered mix output gives the count of channels currently high; it feeds the downstream DAC/PWM stage.
- Half-period changes are glitch-free: each new value takes effect only at that channel's next toggle.

---
 rtl/poly_square_osc.sv | 90 +++++++++
 tb/tb_poly_square_osc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_square_osc.sv
// rtl/poly_square_osc.sv - NUM_CH counter-based square oscillators with a registered popcount mix
// Optional macro POLY_SQUARE_OSC_PHASE_SYNC_EN adds the phase_sync restart input.
module poly_square_osc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 28,
  parameter int MIX_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef POLY_SQUARE_OSC_PHASE_SYNC_EN
  input  logic                    phase_sync,
`endif
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] half_period,
  output logic [NUM_CH-1:0]       wave,
  output logic [NUM_CH-1:0]       toggle_pulse,
  output logic [MIX_W-1:0]        mix_out
);

  if ((2 ** MIX_W) <= NUM_CH) begin : g_mix_w_check
    $error("MIX_W too narrow for NUM_CH");
  end

  logic restart;
`ifdef POLY_SQUARE_OSC_PHASE_SYNC_EN
  assign restart = phase_sync;
`else
  assign restart = 1'b0;
`endif

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hp;
    logic [CNT_W-1:0] hp_in;
    logic [CNT_W-1:0] last;
    logic             wave_q;
    logic             pulse_q;
    logic             at_end;

    assign hp_in = half_period[ch*CNT_W +: CNT_W];
    // A half-period of 0 acts as 1, so the terminal count is 0 in both cases.
    assign last   = (hp == '0) ? '0 : hp - CNT_W'(1);
    assign at_end = (cnt >= last);

    // The shadow hp reloads only at a toggle (or while idle), so a new
    // half-period never cuts the running half-wave short.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        hp      <= '0;
        wave_q  <= 1'b0;
        pulse_q <= 1'b0;
      end else if (restart || !ch_en[ch]) begin
        cnt     <= '0;
        hp      <= hp_in;
        wave_q  <= 1'b0;
        pulse_q <= 1'b0;
      end else if (at_end) begin
        cnt     <= '0;
        hp      <= hp_in;
        wave_q  <= ~wave_q;
        pulse_q <= 1'b1;
      end else begin
        cnt     <= cnt + CNT_W'(1);
        pulse_q <= 1'b0;
      end
    end

    assign wave[ch]         = wave_q;
    assign toggle_pulse[ch] = pulse_q;
  end

  logic [MIX_W-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + MIX_W'(wave[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_out <= '0;
    end else begin
      mix_out <= pop;
    end
  end

endmodule

// File: tb/tb_poly_square_osc.sv
// tb/tb_poly_square_osc.sv - randomized and directed check of poly_square_osc against a half-wave model
module tb_poly_square_osc;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 28;
  localparam int MIX_W  = 3;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*CNT_W-1:0] half_period;
  logic [NUM_CH-1:0]       wave;
  logic [NUM_CH-1:0]       toggle_pulse;
  logic [MIX_W-1:0]        mix_out;
`ifdef POLY_SQUARE_OSC_PHASE_SYNC_EN
  logic                    phase_sync;
`endif

  poly_square_osc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .MIX_W(MIX_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef POLY_SQUARE_OSC_PHASE_SYNC_EN
    .phase_sync   (phase_sync),
`endif
    .ch_en        (ch_en),
    .half_period  (half_period),
    .wave         (wave),
    .toggle_pulse (toggle_pulse),
    .mix_out      (mix_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each half-wave has a length fixed when it starts; it ends after
  // that many enabled edges, and the next length is the input at that moment.
  int unsigned       elapsed [NUM_CH];
  int unsigned       seg_len [NUM_CH];
  logic [NUM_CH-1:0] m_wave;
  logic [NUM_CH-1:0] m_tp;
  int                m_mix;

  function automatic int unsigned eff_of(input int ch);
    int unsigned v;
    v = int'(half_period[ch*CNT_W +: CNT_W]);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      elapsed[ch] = 0;
      seg_len[ch] = 1;
    end
    m_wave = '0;
    m_tp   = '0;
    m_mix  = 0;
  endtask

  task automatic model_edge();
    logic sync_now;
    sync_now = 1'b0;
`ifdef POLY_SQUARE_OSC_PHASE_SYNC_EN
    sync_now = phase_sync;
`endif
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_mix = $countones(m_wave);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (sync_now || !ch_en[ch]) begin
        elapsed[ch] = 0;
        seg_len[ch] = eff_of(ch);
        m_wave[ch]  = 1'b0;
        m_tp[ch]    = 1'b0;
      end else begin
        elapsed[ch]++;
        if (elapsed[ch] >= seg_len[ch]) begin
          m_wave[ch]  = ~m_wave[ch];
          m_tp[ch]    = 1'b1;
          elapsed[ch] = 0;
          seg_len[ch] = eff_of(ch);
        end else begin
          m_tp[ch] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("wave", wave, m_wave);
    check("toggle_pulse", toggle_pulse, m_tp);
    check("mix_out", mix_out, m_mix);
  endtask

  task automatic wait_level(input int idx, input logic lvl, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (wave[idx] !== lvl && n < 64);
  endtask

  task automatic set_hp(input int ch, input int unsigned v);
    half_period[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  int n;
  int peak;

  initial begin
    rst_n       = 1'b0;
    ch_en       = NUM_CH'($urandom);
    half_period = {$urandom, $urandom, $urandom, $urandom};
`ifdef POLY_SQUARE_OSC_PHASE_SYNC_EN
    phase_sync  = 1'b0;
`endif
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    ch_en = '0;
    half_period = '0;
    step();

    // Single channel, half-period 5
    set_hp(0, 5);
    step();
    ch_en = 4'b0001;
    wait_level(0, 1'b1, n);
    check("first_rise_hp5", n, 5);
    wait_level(0, 1'b0, n);
    check("high_len_hp5", n, 5);
    wait_level(0, 1'b1, n);
    check("low_len_hp5", n, 5);

    // Half-period 0 and 1 both toggle every clock
    ch_en = '0;
    set_hp(0, 0);
    step();
    ch_en = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step();
      check("tp_hp0", toggle_pulse[0], 1'b1);
    end
    set_hp(0, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("tp_hp1", toggle_pulse[0], 1'b1);
    end

    // Glitch-free update: 8 -> 3 at count 2 of the high phase
    ch_en = '0;
    set_hp(0, 8);
    step();
    ch_en = 4'b0001;
    wait_level(0, 1'b1, n);
    check("first_rise_hp8", n, 8);
    step();
    step();
    set_hp(0, 3);
    wait_level(0, 1'b0, n);
    check("high_rest_hp8", n, 6);
    wait_level(0, 1'b1, n);
    check("low_len_hp3", n, 3);
    wait_level(0, 1'b0, n);
    check("high_len_hp3", n, 3);

    // Chord 4/5/6/8
    ch_en = '0;
    set_hp(0, 4);
    set_hp(1, 5);
    set_hp(2, 6);
    set_hp(3, 8);
    step();
    ch_en = 4'b1111;
    peak = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (int'(mix_out) > peak) peak = int'(mix_out);
    end
    check("chord_peak", peak, 4);
    wait_level(2, 1'b1, n);
    step();
    ch_en[2] = 1'b0;
    step();
    check("disable_wave2", wave[2], 1'b0);
    check("disable_tp2", toggle_pulse[2], 1'b0);

`ifdef POLY_SQUARE_OSC_PHASE_SYNC_EN
    ch_en = 4'b1111;
    set_hp(2, 4);
    repeat (13) step();
    phase_sync = 1'b1;
    step();
    phase_sync = 1'b0;
    check("sync_wave", wave, 4'b0000);
    check("sync_tp", toggle_pulse, 4'b0000);
    wait_level(0, 1'b1, n);
    check("sync_rise0", n, 4);
    check("sync_align02", wave[2], wave[0]);
`endif

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) ch_en[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) set_hp($urandom_range(0, NUM_CH-1), $urandom_range(0, 9));
`ifdef POLY_SQUARE_OSC_PHASE_SYNC_EN
      phase_sync = ($urandom_range(0, 31) == 0);
`endif
      step();
    end
`ifdef POLY_SQUARE_OSC_PHASE_SYNC_EN
    phase_sync = 1'b0;
`endif

    // Asynchronous reset between edges
    ch_en = 4'b1111;
    repeat (7) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_wave", wave, '0);
    check("async_tp", toggle_pulse, '0);
    check("async_mix", mix_out, '0);
    model_reset();
    step();
    rst_n = 1'b1;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
